// File: rtl/code_lock_pkg.sv
// rtl/code_lock_pkg.sv - shared types and constants for the code_lock block
//
// Contents:
//   BCD_W   : width of one BCD digit.
//   BCD_MAX : largest legal BCD digit value.
//   state_e : lock state (IDLE, ENTRY, OPEN, LOCKOUT, PROGRAM).
//   max3    : helper for sizing the shared cycle timer.
package code_lock_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_OPEN,
    ST_LOCKOUT,
    ST_PROGRAM
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/code_lock_if.sv
// rtl/code_lock_if.sv - keypad-side handshake and status bundle of code_lock
//
// Optional macro: CODE_LOCK_PROG_EN adds prog_i.
// Signals:
//   enable_i       keypad enable; low forces ready_o low
//   digit_valid_i  digit_i valid this cycle
//   digit_i        BCD digit
//   ready_o        digit accepted when digit_valid_i && ready_o
//   clear_i        discard partial entry
//   lock_i         end unlock window early
//   prog_i         (CODE_LOCK_PROG_EN) enter code programming from OPEN
//   unlocked_o     unlock window active
//   fail_o         one-cycle wrong-code pulse
//   lockout_o      lockout active
//   digit_count_o  digits accepted in current entry
//   fail_count_o   consecutive failures
// Modports: master = keypad/controller side, slave = code_lock.
interface code_lock_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_FAILS  = 3
);
  import code_lock_pkg::*;

  localparam int DCW = $clog2(NUM_DIGITS + 1);
  localparam int FCW = $clog2(MAX_FAILS + 1);

  logic             enable_i;
  logic             digit_valid_i;
  logic [BCD_W-1:0] digit_i;
  logic             ready_o;
  logic             clear_i;
  logic             lock_i;
`ifdef CODE_LOCK_PROG_EN
  logic             prog_i;
`endif
  logic             unlocked_o;
  logic             fail_o;
  logic             lockout_o;
  logic [DCW-1:0]   digit_count_o;
  logic [FCW-1:0]   fail_count_o;

  modport master (
    output enable_i, digit_valid_i, digit_i, clear_i, lock_i,
`ifdef CODE_LOCK_PROG_EN
    output prog_i,
`endif
    input  ready_o, unlocked_o, fail_o, lockout_o, digit_count_o, fail_count_o
  );

  modport slave (
    input  enable_i, digit_valid_i, digit_i, clear_i, lock_i,
`ifdef CODE_LOCK_PROG_EN
    input  prog_i,
`endif
    output ready_o, unlocked_o, fail_o, lockout_o, digit_count_o, fail_count_o
  );

endinterface

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with a done flag
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset (count returns to zero)
//   load_i   load value_i (has priority over dec_i)
//   value_i  load value
//   dec_i    decrement by one, saturating at zero
//   done_o   count is zero
// A window of N cycles is produced by loading N-1 on entry and leaving
// on the edge where done_o is seen high.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/code_lock.sv
// rtl/code_lock.sv - serial BCD keypad code lock with unlock window and lockout
//
// Optional macro: CODE_LOCK_PROG_EN (runtime code programming via prog_i).
// Ports:
//   clk_i   sole clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     code_lock_if.slave (digit handshake, clear/lock, status outputs)
// Digits are compared as they arrive against the code; only a sticky
// mismatch flag is kept, never the digits themselves. One cycle_timer
// serves the unlock window, the lockout and the inter-digit timeout, since
// those never overlap.
module code_lock
  import code_lock_pkg::*;
#(
  parameter int                          NUM_DIGITS     = 4,
  parameter logic [NUM_DIGITS*BCD_W-1:0] CODE           = 16'h1082,
  parameter int                          MAX_FAILS      = 3,
  parameter int                          LOCKOUT_CYCLES = 1000,
  parameter int                          OPEN_CYCLES    = 500,
  parameter int                          ENTRY_TIMEOUT  = 200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  code_lock_if.slave bus
);

  localparam int DCW = $clog2(NUM_DIGITS + 1);
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int TW  = $clog2(max3(LOCKOUT_CYCLES, OPEN_CYCLES, ENTRY_TIMEOUT) + 1);

  localparam logic [DCW-1:0] LAST_IDX  = DCW'(NUM_DIGITS - 1);
  localparam logic [FCW-1:0] LAST_FAIL = FCW'(MAX_FAILS - 1);
  localparam logic [TW-1:0]  T_OPEN    = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0]  T_LOCK    = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0]  T_ENTRY   = TW'(ENTRY_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic           mis_q, mis_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fail_q, fail_d;

  logic           ready;
  logic           accept;
  logic           to_idle;
  logic           mis_next;
  logic [BCD_W-1:0] digit_ref;

  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_dec;
  logic           tmr_done;

  logic [NUM_DIGITS*BCD_W-1:0] code_cur;

`ifdef CODE_LOCK_PROG_EN
  // Live code plus a staging buffer so an aborted programming pass leaves
  // the previous code untouched.
  logic [NUM_DIGITS*BCD_W-1:0] code_q, code_d;
  logic [NUM_DIGITS*BCD_W-1:0] pbuf_q, pbuf_d;
  assign code_cur = code_q;
`else
  assign code_cur = CODE;
`endif

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .dec_i   (tmr_dec),
    .done_o  (tmr_done)
  );

  assign ready  = bus.enable_i &&
                  ((state_q == ST_IDLE) || (state_q == ST_ENTRY) || (state_q == ST_PROGRAM));
  assign accept = bus.digit_valid_i && ready;

  // Non-BCD input can never match and is flagged explicitly as well.
  assign digit_ref = code_cur[dcnt_q*BCD_W +: BCD_W];
  assign mis_next  = mis_q || (bus.digit_i != digit_ref) || (bus.digit_i > BCD_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      mis_q   <= 1'b0;
      fcnt_q  <= '0;
      fail_q  <= 1'b0;
`ifdef CODE_LOCK_PROG_EN
      code_q  <= CODE;
      pbuf_q  <= CODE;
`endif
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      mis_q   <= mis_d;
      fcnt_q  <= fcnt_d;
      fail_q  <= fail_d;
`ifdef CODE_LOCK_PROG_EN
      code_q  <= code_d;
      pbuf_q  <= pbuf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    mis_d    = mis_q;
    fcnt_d   = fcnt_q;
    fail_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    to_idle  = 1'b0;
`ifdef CODE_LOCK_PROG_EN
    code_d   = code_q;
    pbuf_d   = pbuf_q;
`endif

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (bus.clear_i) begin
          // clear wins over a digit presented in the same cycle
          to_idle = 1'b1;
        end else if (accept) begin
          if (dcnt_q == LAST_IDX) begin
            dcnt_d = '0;
            mis_d  = 1'b0;
            if (!mis_next) begin
              state_d  = ST_OPEN;
              fcnt_d   = '0;
              tmr_load = 1'b1;
              tmr_val  = T_OPEN;
            end else begin
              fail_d = 1'b1;
              if (fcnt_q == LAST_FAIL) begin
                state_d  = ST_LOCKOUT;
                fcnt_d   = '0;
                tmr_load = 1'b1;
                tmr_val  = T_LOCK;
              end else begin
                state_d  = ST_IDLE;
                fcnt_d   = fcnt_q + 1'b1;
                tmr_load = 1'b1;
                tmr_val  = '0;
              end
            end
          end else begin
            state_d  = ST_ENTRY;
            dcnt_d   = dcnt_q + 1'b1;
            mis_d    = mis_next;
            tmr_load = 1'b1;
            tmr_val  = T_ENTRY;
          end
        end else if (state_q == ST_ENTRY) begin
          if (tmr_done) begin
            to_idle = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end else begin
          // IDLE keeps the timer parked at zero
          to_idle = 1'b1;
        end
      end

      ST_OPEN: begin
        if (bus.lock_i) begin
          to_idle = 1'b1;
`ifdef CODE_LOCK_PROG_EN
        end else if (bus.prog_i) begin
          state_d  = ST_PROGRAM;
          dcnt_d   = '0;
          pbuf_d   = code_q;
          tmr_load = 1'b1;
          tmr_val  = T_ENTRY;
`endif
        end else if (tmr_done) begin
          to_idle = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_LOCKOUT: begin
        if (tmr_done) begin
          to_idle = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end

`ifdef CODE_LOCK_PROG_EN
      ST_PROGRAM: begin
        if (bus.clear_i) begin
          to_idle = 1'b1;
        end else if (accept) begin
          pbuf_d[dcnt_q*BCD_W +: BCD_W] = bus.digit_i;
          if (dcnt_q == LAST_IDX) begin
            code_d  = pbuf_d;
            to_idle = 1'b1;
          end else begin
            dcnt_d   = dcnt_q + 1'b1;
            tmr_load = 1'b1;
            tmr_val  = T_ENTRY;
          end
        end else if (tmr_done) begin
          to_idle = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
`endif

      default: begin
        to_idle = 1'b1;
      end
    endcase

    if (to_idle) begin
      state_d  = ST_IDLE;
      dcnt_d   = '0;
      mis_d    = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.unlocked_o    = (state_q == ST_OPEN);
  assign bus.lockout_o     = (state_q == ST_LOCKOUT);
  assign bus.fail_o        = fail_q;
  assign bus.digit_count_o = dcnt_q;
  assign bus.fail_count_o  = fcnt_q;

endmodule

// File: doc/code_lock.md
# code_lock

Sequential, parametrised keypad code lock: accepts BCD digits one at a time over a valid/ready handshake and compares them incrementally against a compile-time code. It drives an unlock window, counts consecutive failures and enforces a timed lockout. It sits between the keypad debouncer/encoder and the actuator/display logic. It generalises the fixed 4-digit parallel equality check to N digits with serial entry, entry timeout and lockout.

## Interface
- NUM_DIGITS, 4, code length in digits (1..8).
- CODE, 16'h1082, packed BCD code, NUM_DIGITS*4 bits; digit 0 (LSBs) is entered first. The default is the sequence 2,8,0,1.
- MAX_FAILS, 3, consecutive failures that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000, lockout duration in clocks (>=1).
- OPEN_CYCLES, 500, unlock window in clocks (>=1).
- ENTRY_TIMEOUT, 200, idle clocks allowed between digits before a partial entry is discarded (>=1).

Ports:
- clk_i  in  1  sole clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  when low, ready_o is forced low; state and timers keep running.
- digit_valid_i  in  1  digit_i is valid this cycle.
- digit_i  in  4  BCD digit.
- ready_o  out  1  digit accepted on clock edge when digit_valid_i && ready_o.
- clear_i  in  1  discards a partial entry; no failure is counted.
- lock_i  in  1  ends the unlock window early.
- unlocked_o  out  1  high for the whole unlock window.
- fail_o  out  1  one-cycle pulse on a wrong code.
- lockout_o  out  1  high during lockout.
- digit_count_o  out  $clog2(NUM_DIGITS+1)  digits accepted in the current entry.
- fail_count_o  out  $clog2(MAX_FAILS+1)  consecutive failures.

## Operation
- States: IDLE (no digits), ENTRY (1..NUM_DIGITS-1 digits), OPEN, LOCKOUT.
- ready_o = enable_i && state is IDLE or ENTRY. The signal is combinational from registered state.
- Each accepted digit is compared with CODE[4*k+:4], where k = digit_count_o. A sticky mismatch flag ORs in the result of each compare. Entered digits are not stored.
- A non-BCD digit (10..15) is accepted and counts as a mismatch.
- On acceptance of digit NUM_DIGITS-1:
  - Flag clear: go to OPEN and clear fail_count.
  - Flag set: pulse fail_o and increment fail_count. If fail_count reaches MAX_FAILS, go to LOCKOUT and reset fail_count to 0; otherwise go to IDLE.
- OPEN exits to IDLE after OPEN_CYCLES clocks or on lock_i, whichever comes first.
- LOCKOUT exits to IDLE after exactly LOCKOUT_CYCLES clocks. clear_i and lock_i are ignored during lockout.
- ENTRY timeout: after ENTRY_TIMEOUT consecutive clocks with no accepted digit, return to IDLE. Digit count and flag are cleared; no failure is counted. The timer is held at zero in IDLE.
- clear_i in IDLE/ENTRY: return to IDLE. If a digit is accepted in the same cycle, clear wins and the digit is dropped.
- lock_i outside OPEN has no effect.
- fail_count persists across IDLE, timeouts and clears. Only a success or lockout entry clears it.

## Timing
- Reset values: state IDLE, unlocked_o 0, fail_o 0, lockout_o 0, digit_count_o 0, fail_count_o 0. ready_o follows enable_i.
- Verdict latency: last digit accepted at edge t, so unlocked_o or fail_o is high from t+1. When lockout triggers, fail_o and lockout_o rise together at t+1.
- unlocked_o is high for exactly OPEN_CYCLES cycles. If lock_i is sampled high at edge e, unlocked_o is low after e.
- lockout_o is high for exactly LOCKOUT_CYCLES cycles, and ready_o rises in the cycle after it falls.
- Asserting rst_ni low mid-operation returns everything to reset values immediately, including fail_count; this is asynchronous.
- With NUM_DIGITS=1 there is no ENTRY state: the first digit produces the verdict.

## Configuration
- CODE_LOCK_PROG_EN:
  - Defined: adds input prog_i (1 bit). A pulse of prog_i while in OPEN enters PROGRAM. The next NUM_DIGITS accepted digits overwrite a code register initialised from CODE at reset, then the block returns to IDLE. ready_o is also high in PROGRAM, and PROGRAM obeys the entry timeout and clear_i. On abort, the old code is retained.
  - Undefined: no prog_i port; the code is the CODE constant; no PROGRAM state.

## Structure
- Package code_lock_pkg holds:
  - the state enum (IDLE, ENTRY, OPEN, LOCKOUT, PROGRAM);
  - the BCD width constant (4);
  - the BCD max constant (9).
- Sub-module cycle_timer: loadable down-counter with a done flag, parametrised by width. It is instantiated once and shared by OPEN, LOCKOUT and the entry timeout, which are mutually exclusive in time.

## Test plan
- Default params, enter 2,8,0,1 → unlocked_o high from the cycle after '1', for 500 cycles; fail_count_o=0.
- Enter 2,8,0,2 three times → fail_o pulses 3 times. On the third, lockout_o is high for 1000 cycles, ready_o is 0 throughout, and fail_count_o=0 after.
- Enter 2,8, then wait 200 cycles → digit_count_o returns to 0, no fail_o; then enter 2,8,0,1 → unlock.
- Enter 2,8,0; assert clear_i together with a valid '1' → digit dropped, IDLE, no verdict.
- Enter a digit of 4'hA in position 1 → fail_o after the 4th digit. Then unlock and assert lock_i 10 cycles in → unlocked_o falls.
- Assert rst_ni low mid-lockout → all outputs return to reset values; an immediate correct code unlocks.
